// File: rtl/sop_check_pkg.sv
// Shared types and expected truth-table masks for the SOP self-check sweep.
// Mask bit i is the required value of F at minterm i.
package sop_check_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;

    localparam int TW_MAX = 16;

    localparam logic [7:0] SOP_1_2_4_7 = 8'h96;
    localparam logic [3:0] SOP_XOR2    = 4'h6;
    localparam logic [7:0] SOP_MAJ3    = 8'hE8;

endpackage

// File: rtl/lsb_prio_enc.sv
// Priority encoder: index of the lowest set bit of mask_i, purely combinational.
// vld_o is low (and idx_o is 0) when no bit is set.
module lsb_prio_enc #(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic [W-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps the select of a combinational block through every minterm, captures F,
// and compares the measured truth table against EXP_MASK; done pulses one cycle after DONE.
module minterm_sweep_checker
    import sop_check_pkg::*;
#(
    parameter int                      N_VARS        = 3,
    parameter logic [(2**N_VARS)-1:0]  EXP_MASK      = SOP_1_2_4_7,
    parameter int                      SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     f_i,
    output logic [N_VARS-1:0]        xyz_o,
    output logic                     en_n_o,
    output logic                     busy,
    output logic                     done,
    output logic [(2**N_VARS)-1:0]   table_o,
    output logic [(2**N_VARS)-1:0]   mismatch_o,
    output logic                     pass,
    output logic [N_VARS-1:0]        first_fail_o
);

    localparam int                TW        = 2**N_VARS;
    localparam logic [N_VARS-1:0] IDX_LAST  = N_VARS'(TW - 1);
    localparam logic [3:0]        WAIT_LAST = 4'(SETTLE_CYCLES - 1);

    sweep_state_t      state_q, state_d;
    logic [N_VARS-1:0] idx_q;
    logic [3:0]        wait_q;
    logic [TW-1:0]     table_q, mismatch_q;
    logic              pass_q, done_q;
    logic [N_VARS-1:0] ff_q;

    logic [TW-1:0]     mism_w;
    logic [N_VARS-1:0] ff_idx;
    logic              ff_vld;

    assign mism_w = table_q ^ EXP_MASK;

    lsb_prio_enc #(.W(TW), .IW(N_VARS)) u_ff_enc (
        .mask_i (mism_w),
        .idx_o  (ff_idx),
        .vld_o  (ff_vld)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (wait_q == WAIT_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (idx_q == IDX_LAST) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            table_q    <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            ff_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            // Counter restarts on every entry into SETTLE.
            wait_q  <= (state_q == SETTLE && state_d == SETTLE) ? wait_q + 4'd1 : 4'd0;
            if (abort) begin
                if (state_q != IDLE) begin
                    idx_q  <= '0;
                    pass_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            idx_q      <= '0;
                            table_q    <= '0;
                            mismatch_q <= '0;
                            pass_q     <= 1'b0;
                        end
                    end
                    SAMPLE: begin
                        table_q[idx_q] <= f_i;
                        if (idx_q != IDX_LAST) idx_q <= idx_q + N_VARS'(1);
                    end
                    DONE: begin
                        done_q     <= 1'b1;
                        mismatch_q <= mism_w;
                        pass_q     <= (mism_w == '0);
                        ff_q       <= ff_vld ? ff_idx : '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy         = (state_q == SETTLE) || (state_q == SAMPLE);
    assign en_n_o       = ~busy;
    assign xyz_o        = idx_q;
    assign done         = done_q;
    assign table_o      = table_q;
    assign mismatch_o   = mismatch_q;
    assign pass         = pass_q;
    assign first_fail_o = ff_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: default 3-input instance plus a 2-input, 3-settle XOR instance,
// checked every cycle against a cycle-count model and pinned with hand-computed results.
module tb_minterm_sweep_checker;
    import sop_check_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, abort0, start1, abort1;
    logic [7:0] fm [2];
    logic       f0, f1;

    logic [2:0] xyz0, ff0;
    logic [7:0] tab0, mis0;
    logic       en0, busy0, done0, pass0;
    logic [1:0] xyz1, ff1;
    logic [3:0] tab1, mis1;
    logic       en1, busy1, done1, pass1;

    assign f0 = fm[0][xyz0];
    assign f1 = fm[1][xyz1];

    minterm_sweep_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_i(f0),
        .xyz_o(xyz0), .en_n_o(en0), .busy(busy0), .done(done0), .table_o(tab0),
        .mismatch_o(mis0), .pass(pass0), .first_fail_o(ff0)
    );

    minterm_sweep_checker #(.N_VARS(2), .EXP_MASK(4'h6), .SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_i(f1),
        .xyz_o(xyz1), .en_n_o(en1), .busy(busy1), .done(done1), .table_o(tab1),
        .mismatch_o(mis1), .pass(pass1), .first_fail_o(ff1)
    );

    logic [7:0] a_xyz [2], a_tab [2], a_mis [2], a_ff [2];
    logic       a_en [2], a_busy [2], a_done [2], a_pass [2];
    assign a_xyz[0] = 8'(xyz0);  assign a_xyz[1] = 8'(xyz1);
    assign a_tab[0] = tab0;      assign a_tab[1] = 8'(tab1);
    assign a_mis[0] = mis0;      assign a_mis[1] = 8'(mis1);
    assign a_ff[0]  = 8'(ff0);   assign a_ff[1]  = 8'(ff1);
    assign a_en[0]  = en0;       assign a_en[1]  = en1;
    assign a_busy[0] = busy0;    assign a_busy[1] = busy1;
    assign a_done[0] = done0;    assign a_done[1] = done1;
    assign a_pass[0] = pass0;    assign a_pass[1] = pass1;

    // Per-instance configuration seen by the model.
    int         TWc [2]  = '{8, 4};
    int         Sc  [2]  = '{1, 3};
    logic [7:0] EXPc [2] = '{8'h96, 8'h06};

    // Model state: k = cycles since the start-accept edge, -1 when idle.
    int         k [2], m_xyz [2], m_ff [2];
    logic [7:0] m_tab [2], m_mis [2];
    logic       m_pass [2], m_done [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, c, $time, act, exp);
        end
    endtask

    task automatic set_start(input int c, input logic v);
        if (c == 0) start0 = v; else start1 = v;
    endtask

    // One sweep from a start pulse; optionally re-pulses start for one cycle at edge poke_at.
    task automatic run(input int c, input int poke_at, output int lat);
        lat = -1;
        @(negedge clk); set_start(c, 1'b1);
        @(posedge clk); #1; set_start(c, 1'b0);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == poke_at) set_start(c, 1'b1);
            if (n == poke_at + 1) set_start(c, 1'b0);
            if (a_done[c]) begin
                lat = n;
                break;
            end
        end
        set_start(c, 1'b0);
    endtask

    task automatic wait_xyz0(input int v);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (xyz0 == 3'(v) && busy0) return;
        end
        chk("wait_xyz_timeout", 0, 8'(xyz0), 8'(v));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xyz"}, 0, a_xyz[0], 8'h00);
        chk({tag, "_en_n"}, 0, 8'(en0), 8'h01);
        chk({tag, "_busy"}, 0, 8'(busy0), 8'h00);
        chk({tag, "_done"}, 0, 8'(done0), 8'h00);
        chk({tag, "_table"}, 0, tab0, 8'h00);
        chk({tag, "_mismatch"}, 0, mis0, 8'h00);
        chk({tag, "_pass"}, 0, 8'(pass0), 8'h00);
        chk({tag, "_ff"}, 0, a_ff[0], 8'h00);
    endtask

    initial begin
        int lat, dcnt, d1, d2;
        rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        fm[0] = 8'h96; fm[1] = 8'h06;
        fork
            // Model: predicts every output from the cycle count since acceptance.
            forever begin
                @(posedge clk or negedge rst_n);
                for (int c = 0; c < 2; c++) begin
                    int L, per, idx;
                    logic st, ab;
                    if (!rst_n) begin
                        k[c] = -1; m_xyz[c] = 0; m_ff[c] = 0; m_tab[c] = 0;
                        m_mis[c] = 0; m_pass[c] = 0; m_done[c] = 0;
                    end else begin
                        st  = (c == 0) ? start0 : start1;
                        ab  = (c == 0) ? abort0 : abort1;
                        per = Sc[c] + 1;
                        L   = TWc[c] * per;
                        m_done[c] = 0;
                        if (ab) begin
                            if (k[c] >= 0) begin k[c] = -1; m_xyz[c] = 0; m_pass[c] = 0; end
                        end else if (k[c] < 0) begin
                            if (st) begin
                                k[c] = 0; m_xyz[c] = 0; m_tab[c] = 0; m_mis[c] = 0; m_pass[c] = 0;
                            end
                        end else if (k[c] == L) begin
                            k[c] = -1; m_done[c] = 1;
                            m_mis[c]  = m_tab[c] ^ EXPc[c];
                            m_pass[c] = (m_mis[c] == 8'h00);
                            m_ff[c]   = 0;
                            for (int i = TWc[c] - 1; i >= 0; i--) if (m_mis[c][i]) m_ff[c] = i;
                        end else begin
                            idx = k[c] / per;
                            if (k[c] % per == per - 1) begin
                                m_tab[c][idx] = fm[c][idx];
                                if (idx < TWc[c] - 1) m_xyz[c] = idx + 1;
                            end
                            k[c]++;
                        end
                    end
                end
            end
            // Compare: every output of both instances on every falling edge.
            forever begin
                @(negedge clk);
                for (int c = 0; c < 2; c++) begin
                    logic bz;
                    bz = (k[c] >= 0) && (k[c] < TWc[c] * (Sc[c] + 1));
                    chk("busy", c, 8'(a_busy[c]), 8'(bz));
                    chk("en_n", c, 8'(a_en[c]), 8'(!bz));
                    chk("done", c, 8'(a_done[c]), 8'(m_done[c]));
                    chk("xyz", c, a_xyz[c], 8'(m_xyz[c]));
                    chk("table", c, a_tab[c], m_tab[c]);
                    chk("mismatch", c, a_mis[c], m_mis[c]);
                    chk("pass", c, 8'(a_pass[c]), 8'(m_pass[c]));
                    chk("first_fail", c, a_ff[c], 8'(m_ff[c]));
                end
            end
            // Directed stimulus with hand-computed expectations.
            begin
                #1;
                chk_reset_vals("rst");
                chk("rst_en_n", 1, 8'(en1), 8'h01);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;

                run(0, -1, lat);
                chk("golden_lat", 0, 8'(lat), 8'd17);
                chk("golden_table", 0, tab0, 8'h96);
                chk("golden_mismatch", 0, mis0, 8'h00);
                chk("golden_pass", 0, 8'(pass0), 8'h01);
                chk("golden_ff", 0, a_ff[0], 8'h00);

                fm[0] = 8'h00;
                run(0, -1, lat);
                chk("stuck0_table", 0, tab0, 8'h00);
                chk("stuck0_mismatch", 0, mis0, 8'h96);
                chk("stuck0_pass", 0, 8'(pass0), 8'h00);
                chk("stuck0_ff", 0, a_ff[0], 8'h01);

                fm[0] = 8'h97;
                run(0, -1, lat);
                chk("extra0_mismatch", 0, mis0, 8'h01);
                chk("extra0_ff", 0, a_ff[0], 8'h00);
                chk("extra0_pass", 0, 8'(pass0), 8'h00);

                fm[0] = 8'h16;
                run(0, -1, lat);
                chk("miss7_mismatch", 0, mis0, 8'h80);
                chk("miss7_ff", 0, a_ff[0], 8'h07);

                run(1, -1, lat);
                chk("xor_lat", 1, 8'(lat), 8'd17);
                chk("xor_table", 1, a_tab[1], 8'h06);
                chk("xor_pass", 1, 8'(pass1), 8'h01);
                fm[1] = 8'h09;
                run(1, -1, lat);
                chk("xnor_mismatch", 1, a_mis[1], 8'h0F);
                chk("xnor_ff", 1, a_ff[1], 8'h00);
                chk("xnor_pass", 1, 8'(pass1), 8'h00);

                // start while busy and during DONE is ignored
                fm[0] = 8'h96;
                run(0, 5, lat);
                chk("busy_start_lat", 0, 8'(lat), 8'd17);
                run(0, 16, lat);
                chk("done_start_lat", 0, 8'(lat), 8'd17);
                repeat (2) @(posedge clk);
                #1 chk("no_restart_busy", 0, 8'(busy0), 8'h00);

                // start held high: back-to-back sweeps, 18 cycles apart
                @(negedge clk); start0 = 1'b1;
                @(posedge clk); #1;
                d1 = -1; d2 = -1;
                for (int n = 1; n <= 60; n++) begin
                    @(posedge clk); #1;
                    if (done0) begin
                        if (d1 < 0) d1 = n;
                        else begin d2 = n; start0 = 1'b0; break; end
                    end
                end
                start0 = 1'b0;
                chk("held_done1", 0, 8'(d1), 8'd17);
                chk("held_done2", 0, 8'(d2), 8'd35);
                repeat (3) @(posedge clk);
                #1 chk("held_stop_busy", 0, 8'(busy0), 8'h00);

                // abort beats start in IDLE
                @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
                @(posedge clk); #1; start0 = 1'b0; abort0 = 1'b0;
                chk("abort_vs_start_busy", 0, 8'(busy0), 8'h00);

                // abort mid-sweep at minterm 5
                @(negedge clk); start0 = 1'b1;
                @(posedge clk); #1; start0 = 1'b0;
                wait_xyz0(5);
                abort0 = 1'b1;
                @(posedge clk); #1; abort0 = 1'b0;
                chk("abort_en_n", 0, 8'(en0), 8'h01);
                chk("abort_busy", 0, 8'(busy0), 8'h00);
                chk("abort_xyz", 0, a_xyz[0], 8'h00);
                chk("abort_pass", 0, 8'(pass0), 8'h00);
                chk("abort_partial_table", 0, tab0, 8'h16);
                dcnt = 0;
                for (int n = 0; n < 25; n++) begin
                    @(posedge clk); #1;
                    if (done0) dcnt++;
                end
                chk("abort_no_done", 0, 8'(dcnt), 8'h00);

                // reset mid-sweep at minterm 3, then a clean restart
                @(negedge clk); start0 = 1'b1;
                @(posedge clk); #1; start0 = 1'b0;
                wait_xyz0(3);
                rst_n = 1'b0;
                #1 chk_reset_vals("midrst");
                @(negedge clk); rst_n = 1'b1;
                run(0, -1, lat);
                chk("restart_lat", 0, 8'(lat), 8'd17);
                chk("restart_pass", 0, 8'(pass0), 8'h01);
                repeat (2) @(negedge clk);
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
